// File: rtl/display_pkg.sv
// display_pkg: digit width, special codes and packed-word digit extraction
package display_pkg;
  localparam int DIGIT_W = 4;
  localparam int MAX_DIGITS = 64;
  localparam int PW = DIGIT_W * MAX_DIGITS;
  localparam logic [DIGIT_W-1:0] CODE_DP = 4'hA;
  localparam logic [DIGIT_W-1:0] CODE_BLANK = 4'hF;
  // callers widen their word to PW bits, so at most MAX_DIGITS digits are supported
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [PW-1:0] w, input int i);
    return w[i*DIGIT_W +: DIGIT_W];
  endfunction
endpackage

// File: rtl/seg_lz_blank.sv
// seg_lz_blank: per-digit effective codes with optional leading-zero blanking
module seg_lz_blank
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  logic [DIGIT_W*NUM_DIGITS-1:0] word_i,
  input  logic                          lz_en_i,
  output logic [DIGIT_W*NUM_DIGITS-1:0] code_o
);
  logic [DIGIT_W-1:0] d;
  logic zero_above;
  // walk from the most significant digit down; 4'hA..4'hF count as non-zero
  always_comb begin
    zero_above = 1'b1;
    code_o = '0;
    d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d = digit_at(PW'(word_i), i);
      zero_above = zero_above && (d == 4'h0);
      code_o[i*DIGIT_W +: DIGIT_W] = (lz_en_i && i > 0 && zero_above) ? CODE_BLANK : d;
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan with guard gap and frame-synchronous updates
module seg_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic                          lz_en,
  output logic [DIGIT_W-1:0]            Q,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic                          frame_start,
  output logic                          pending
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int WW = DIGIT_W * NUM_DIGITS;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WW-1:0] pend_q, pend_d, disp_q, disp_d, eff;
  logic pending_q, pending_d;
  logic [DIGIT_W-1:0] q_q, q_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic fs_q, fs_d;
  logic wrap_slot, wrap_frame;

  assign wrap_slot  = div_cnt_q == CW'(REFRESH_DIV - 1);
  assign wrap_frame = wrap_slot && idx_q == IW'(NUM_DIGITS - 1);

  seg_lz_blank #(.NUM_DIGITS(NUM_DIGITS)) u_lz (
    .word_i  (disp_d),
    .lz_en_i (lz_en),
    .code_o  (eff)
  );

  // outputs are precomputed from next-state values so they line up with the held count
  always_comb begin
    div_cnt_d = wrap_slot ? '0 : div_cnt_q + CW'(1);
    idx_d = wrap_frame ? '0 : wrap_slot ? idx_q + IW'(1) : idx_q;
    pend_d = load ? digits_in : pend_q;
    disp_d = wrap_frame ? (load ? digits_in : pending_q ? pend_q : disp_q) : disp_q;
    pending_d = wrap_frame ? 1'b0 : (load | pending_q);
    q_d = digit_at(PW'(eff), int'(idx_d));
    anode_d = div_cnt_d < CW'(GUARD_CYCLES) ? '1 : ~(NUM_DIGITS'(1) << idx_d);
    fs_d = div_cnt_d == '0 && idx_d == '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q <= '0;
      pend_q <= '0;
      disp_q <= {NUM_DIGITS{CODE_BLANK}};
      pending_q <= 1'b0;
      q_q <= CODE_BLANK;
      anode_q <= '1;
      fs_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      pending_q <= pending_d;
      q_q <= q_d;
      anode_q <= anode_d;
      fs_q <= fs_d;
    end
  end

  assign Q = q_q;
  assign anode = anode_q;
  assign frame_start = fs_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random scan checks against a frame-level display model
module tb_seg_scan_ctrl;
  localparam int N = 4, R = 8, G = 2;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, lz_en = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] Q;
  logic [3:0] anode;
  logic frame_start, pending;
  int n_assert = 0, n_fail = 0;
  int t = 0;
  logic [15:0] m_disp = 16'hFFFF, m_pend_w = '0;
  logic m_pend = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .digits_in   (digits_in),
    .lz_en       (lz_en),
    .Q           (Q),
    .anode       (anode),
    .frame_start (frame_start),
    .pending     (pending)
  );

  function automatic logic [3:0] eff(input logic [15:0] w, input int i, input logic lz);
    logic [15:0] up;
    up = w >> (4 * i);
    return (lz && i > 0 && up == 16'h0) ? 4'hF : up[3:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all(input logic lz);
    int slot, cnt;
    logic [3:0] ea;
    slot = (t / R) % N;
    cnt = t % R;
    ea = 4'b0001 << slot;
    ea = cnt < G ? 4'hF : ~ea;
    chk("anode", anode, ea);
    chk("one_anode_max", $countones(~anode) <= 1, 1);
    chk("Q", Q, eff(m_disp, slot, lz));
    chk("frame_start", frame_start, t > 0 && t % (N * R) == 0);
    chk("pending", pending, m_pend);
  endtask

  task automatic step();
    logic lz_s, ld;
    logic [15:0] d;
    lz_s = lz_en;
    ld = load;
    d = digits_in;
    @(posedge clk);
    if (t % R == R - 1 && (t / R) % N == N - 1) begin
      if (ld) begin
        m_disp = d;
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_disp = m_pend_w;
        m_pend = 1'b0;
      end
    end else if (ld) begin
      m_pend_w = d;
      m_pend = 1'b1;
    end
    t++;
    #1;
    check_all(lz_s);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic go_to(input int s, input int c);
    for (int k = 0; k < N * R && !((t / R) % N == s && t % R == c); k++) step();
  endtask

  task automatic release_rst();
    rst = 1'b0;
    t = 0;
    m_disp = 16'hFFFF;
    m_pend = 1'b0;
    check_all(lz_en);
  endtask

  task automatic load_word(input logic [15:0] w);
    digits_in = w;
    load = 1'b1;
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 release_rst();
    run(70);
    load_word(16'h4321);
    run(70);
    lz_en = 1'b1;
    load_word(16'h0050);
    run(70);
    lz_en = 1'b0;
    run(40);
    lz_en = 1'b1;
    load_word(16'h0000);
    run(70);
    lz_en = 1'b0;
    load_word(16'h1111);
    run(70);
    go_to(2, 3);
    load_word(16'h2222);
    chk("tear_free_pending", pending, 1);
    run(40);
    go_to(0, 4);
    load_word(16'h5678);
    run(5);
    load_word(16'h8765);
    run(70);
    go_to(3, 7);
    load_word(16'h0987);
    chk("wrap_load_pending", pending, 0);
    run(40);
    lz_en = 1'b1;
    load_word(16'hA0F9);
    run(70);
    load_word(16'h1234);
    run(3);
    #3 rst = 1'b1;
    #1;
    chk("rst_anode", anode, 4'hF);
    chk("rst_Q", Q, 4'hF);
    chk("rst_pending", pending, 0);
    chk("rst_frame_start", frame_start, 0);
    repeat (2) @(posedge clk);
    #1 release_rst();
    run(70);
    repeat (800) begin
      if ($urandom_range(0, 15) == 0) begin
        digits_in = 16'($urandom);
        load = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) lz_en = 1'($urandom_range(0, 1));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
